// File: rtl/display_shift_controller.sv
// display_shift_controller
//   Streams NUM_DIGITS x SEG_BITS segment patterns MSB-first onto a chain of
//   external shift registers (data / shift clock / storage latch). Frames come
//   from a periodic refresh timer or an on-demand request; the digit bus is
//   snapshotted at LOAD so each frame is coherent.
//
// Ports
//   i_clk          system clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   i_en           enables the refresh timer and the start of new frames
//   i_start        on-demand refresh request, level-sampled every cycle
//   i_digits       packed patterns, digit 0 in the MSBs, dp,g..a within a digit
//   i_blank_mask   bit n forces digit n to all-zero in the frame
//   o_busy         frame in progress (LOAD through LATCH)
//   o_done         one-cycle pulse after the latch phase
//   o_serial_data  serial data, MSB first
//   o_serial_clk   shift clock, external registers sample on its rising edge
//   o_serial_latch storage-register latch, active-high
module display_shift_controller #(
    parameter int SYS_CLK_HZ     = 50_000_000,
    parameter int REFRESH_HZ     = 100,
    parameter int SERIAL_CLK_DIV = 4,
    parameter int NUM_DIGITS     = 6,
    parameter int SEG_BITS       = 8
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic                           i_en,
    input  logic                           i_start,
    input  logic [NUM_DIGITS*SEG_BITS-1:0] i_digits,
    input  logic [NUM_DIGITS-1:0]          i_blank_mask,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_serial_data,
    output logic                           o_serial_clk,
    output logic                           o_serial_latch
);

    localparam int PERIOD = SYS_CLK_HZ / REFRESH_HZ;
    localparam int NB     = NUM_DIGITS * SEG_BITS;
    localparam int TMR_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int BIT_W  = (NB > 1) ? $clog2(NB) : 1;
    localparam int DIV_W  = (SERIAL_CLK_DIV > 1) ? $clog2(SERIAL_CLK_DIV) : 1;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PERIOD - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NB - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SERIAL_CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SHIFT_LO, S_SHIFT_HI, S_LATCH, S_DONE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [DIV_W-1:0] r_div, w_div_nxt;
    logic [BIT_W-1:0] r_bit, w_bit_nxt;
    logic [NB-1:0]    r_shift, w_shift_nxt;
    logic [NB-1:0]    w_frame;
    logic             r_pending;
    logic             w_tick, w_req, w_enter_load;
    logic             r_busy, r_done, r_sdata, r_sclk, r_latch;

    // Blanked digits are zeroed before capture.
    for (genvar n = 0; n < NUM_DIGITS; n++) begin : g_blank
        assign w_frame[NB-1-n*SEG_BITS -: SEG_BITS] =
            i_blank_mask[n] ? '0 : i_digits[NB-1-n*SEG_BITS -: SEG_BITS];
    end

    // Refresh timer: free-runs while enabled, parked at 0 otherwise.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)            r_timer <= '0;
        else if (!i_en)            r_timer <= '0;
        else if (r_timer == TMR_LAST) r_timer <= '0;
        else                       r_timer <= r_timer + TMR_W'(1);
    end

    assign w_tick       = i_en && (r_timer == TMR_LAST);
    assign w_req        = w_tick || (i_start && i_en);
    // LOAD is only ever entered from IDLE or DONE, so next==LOAD marks entry.
    assign w_enter_load = (w_state_nxt == S_LOAD);

    // Single pending flag coalesces all requests seen before the next LOAD.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)        r_pending <= 1'b0;
        else if (w_enter_load) r_pending <= 1'b0;
        else if (w_req)        r_pending <= 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        case (r_state)
            S_IDLE: begin
                if (r_pending && i_en) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_shift_nxt = w_frame;
                w_bit_nxt   = BIT_LAST;
                w_div_nxt   = '0;
                w_state_nxt = S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
                if (r_div == DIV_LAST) begin
                    w_div_nxt   = '0;
                    w_state_nxt = S_SHIFT_HI;
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
            S_SHIFT_HI: begin
                if (r_div == DIV_LAST) begin
                    w_div_nxt = '0;
                    if (r_bit == '0) begin
                        w_state_nxt = S_LATCH;
                    end else begin
                        w_shift_nxt = {r_shift[NB-2:0], 1'b0};
                        w_bit_nxt   = r_bit - BIT_W'(1);
                        w_state_nxt = S_SHIFT_LO;
                    end
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
            S_LATCH: begin
                if (r_div == DIV_LAST) begin
                    w_div_nxt   = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
            S_DONE: begin
                // Back-to-back frame when a request arrived during this one.
                w_state_nxt = (r_pending && i_en) ? S_LOAD : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Outputs are decoded from next-state values and registered, so each
    // pin is a flop that lines up with the state it belongs to.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sdata <= 1'b0;
            r_sclk  <= 1'b0;
            r_latch <= 1'b0;
        end else begin
            r_busy  <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_SHIFT_LO) ||
                       (w_state_nxt == S_SHIFT_HI) || (w_state_nxt == S_LATCH);
            r_done  <= (w_state_nxt == S_DONE);
            r_sdata <= ((w_state_nxt == S_SHIFT_LO) || (w_state_nxt == S_SHIFT_HI)) ?
                       w_shift_nxt[NB-1] : 1'b0;
            r_sclk  <= (w_state_nxt == S_SHIFT_HI);
            r_latch <= (w_state_nxt == S_LATCH);
        end
    end

    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_serial_data  = r_sdata;
    assign o_serial_clk   = r_sclk;
    assign o_serial_latch = r_latch;

endmodule

// File: tb/tb_display_shift_controller.sv
module tb_display_shift_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT A: one-shot frames, default serial divider.
    logic        en_a = 1'b0, start_a = 1'b0;
    logic [47:0] digits_a = '0;
    logic [5:0]  mask_a = '0;
    logic        busy_a, done_a, sd_a, sc_a, sl_a;

    // DUT B: periodic refresh, divider 1.
    logic        en_b = 1'b0;
    logic [47:0] digits_b = 48'h0123_4567_89AB;
    logic        busy_b, done_b, sd_b, sc_b, sl_b;

    display_shift_controller #(.SYS_CLK_HZ(1000), .REFRESH_HZ(1), .SERIAL_CLK_DIV(4),
                               .NUM_DIGITS(6), .SEG_BITS(8)) u_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(en_a), .i_start(start_a),
        .i_digits(digits_a), .i_blank_mask(mask_a),
        .o_busy(busy_a), .o_done(done_a), .o_serial_data(sd_a),
        .o_serial_clk(sc_a), .o_serial_latch(sl_a));

    display_shift_controller #(.SYS_CLK_HZ(1000), .REFRESH_HZ(10), .SERIAL_CLK_DIV(1),
                               .NUM_DIGITS(6), .SEG_BITS(8)) u_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(en_b), .i_start(1'b0),
        .i_digits(digits_b), .i_blank_mask(6'b0),
        .o_busy(busy_b), .o_done(done_b), .o_serial_data(sd_b),
        .o_serial_clk(sc_b), .o_serial_latch(sl_b));

    int n_pass = 0, n_chk = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [47:0] digits;
        logic [5:0]  mask;
        logic        scramble;  // corrupt inputs mid-frame
        logic [47:0] exp_word;
    } vec_t;
    vec_t vecs[7];

    logic [47:0] f_word;
    int f_bits, f_busy, f_latch, f_done, f_bad, f_rise;

    // One frame on DUT A; everything sampled on the falling edge.
    task automatic run_frame(input logic [47:0] d, input logic [5:0] m, input logic scr);
        logic prev_sc;
        int first_busy, first_rise;
        prev_sc = 1'b0; first_busy = -1; first_rise = -1;
        f_word = '0; f_bits = 0; f_busy = 0; f_latch = 0; f_done = 0; f_bad = 0;
        digits_a = d; mask_a = m;
        @(negedge clk) en_a = 1'b0;          // park refresh timer at 0
        @(negedge clk) begin en_a = 1'b1; start_a = 1'b1; end
        @(negedge clk) start_a = 1'b0;
        for (int c = 0; c < 410; c++) begin
            @(negedge clk);
            if (busy_a) begin
                f_busy++;
                if (first_busy < 0) first_busy = c;
            end
            if (sc_a && !prev_sc) begin
                f_word = {f_word[46:0], sd_a};
                f_bits++;
                if (first_rise < 0) first_rise = c;
            end
            prev_sc = sc_a;
            if (sl_a) begin
                f_latch++;
                if (sc_a || sd_a) f_bad++;
            end
            if (done_a) begin
                f_done++;
                if (busy_a || sl_a) f_bad++;
            end
            if (scr && c == 100) begin digits_a = ~d; mask_a = ~m; end
        end
        digits_a = d; mask_a = m;
        f_rise = first_rise - first_busy;
    endtask

    initial begin
        vecs[0] = '{48'hF00F_A55A_817E, 6'b000000, 1'b0, 48'hF00F_A55A_817E};
        vecs[1] = '{48'hF00F_A55A_817E, 6'b000101, 1'b0, 48'h000F_005A_817E};
        vecs[2] = '{48'h1234_5678_9ABC, 6'b111111, 1'b0, 48'h0000_0000_0000};
        vecs[3] = '{48'h1234_5678_9ABC, 6'b100000, 1'b1, 48'h1234_5678_9A00};
        vecs[4] = '{48'hFFFF_FFFF_FFFF, 6'b000000, 1'b0, 48'hFFFF_FFFF_FFFF};
        vecs[5] = '{48'h0000_0000_0001, 6'b000000, 1'b1, 48'h0000_0000_0001};
        vecs[6] = '{48'h80FF_00FF_EE11, 6'b010010, 1'b0, 48'h8000_00FF_0011};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outs_a", {busy_a, done_a, sd_a, sc_a, sl_a}, 5'b0);
        check("reset_outs_b", {busy_b, done_b, sd_b, sc_b, sl_b}, 5'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_after_reset", {busy_a, busy_b}, 2'b0);

        // Table-driven frames
        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i].digits, vecs[i].mask, vecs[i].scramble);
            check($sformatf("word[%0d]", i), f_word, vecs[i].exp_word);
            check($sformatf("bits[%0d]", i), f_bits, 48);
            check($sformatf("busy_cycles[%0d]", i), f_busy, 389);
            check($sformatf("latch_cycles[%0d]", i), f_latch, 4);
            check($sformatf("done_pulses[%0d]", i), f_done, 1);
            check($sformatf("phase_err[%0d]", i), f_bad, 0);
            if (i == 0) check("first_sclk_rise", f_rise, 5);
        end

        // Request coalescing: 5 pulses during a frame -> one extra frame
        begin
            int rises, dones, gap_bad;
            logic prev_busy, prev_done;
            rises = 0; dones = 0; gap_bad = 0; prev_busy = 1'b0; prev_done = 1'b0;
            digits_a = 48'hF00F_A55A_817E; mask_a = '0;
            @(negedge clk) en_a = 1'b0;
            @(negedge clk) begin en_a = 1'b1; start_a = 1'b1; end
            @(negedge clk) start_a = 1'b0;
            for (int c = 0; c < 850; c++) begin
                @(negedge clk);
                if (busy_a && !prev_busy) begin
                    rises++;
                    if (rises == 2 && !prev_done) gap_bad++;
                end
                if (done_a) dones++;
                prev_busy = busy_a; prev_done = done_a;
                start_a = (c == 50 || c == 80 || c == 110 || c == 140 || c == 170);
            end
            start_a = 1'b0;
            check("coalesce_frames", rises, 2);
            check("coalesce_dones", dones, 2);
            check("coalesce_back_to_back", gap_bad, 0);
        end

        // Abort: reset after 20 bits have been clocked out
        begin
            int rises, latched;
            logic prev_sc;
            rises = 0; latched = 0; prev_sc = 1'b0;
            @(negedge clk) en_a = 1'b0;
            @(negedge clk) begin en_a = 1'b1; start_a = 1'b1; end
            @(negedge clk) start_a = 1'b0;
            for (int c = 0; c < 400 && rises < 20; c++) begin
                @(negedge clk);
                if (sc_a && !prev_sc) rises++;
                prev_sc = sc_a;
                if (sl_a) latched++;
            end
            check("abort_reached_bit20", rises, 20);
            #2 rst_n = 1'b0;
            #1 check("abort_outs_immediate", {busy_a, done_a, sd_a, sc_a, sl_a}, 5'b0);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (busy_a || done_a || sd_a || sc_a || sl_a) latched++;
            end
            rst_n = 1'b1;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (busy_a || sl_a) latched++;
            end
            check("abort_no_latch_no_restart", latched, 0);
            en_a = 1'b0;
        end

        // Periodic refresh on DUT B
        begin
            int rises, last, spacing_bad, first, dones_off;
            logic prev_busy;
            rises = 0; last = -1; spacing_bad = 0; first = -1; dones_off = 0;
            prev_busy = 1'b0;
            @(negedge clk) en_b = 1'b1;
            for (int c = 0; c < 550; c++) begin
                @(negedge clk);
                if (busy_b && !prev_busy) begin
                    rises++;
                    if (first < 0) first = c;
                    if (last >= 0 && c - last != 100) spacing_bad++;
                    last = c;
                end
                prev_busy = busy_b;
            end
            check("periodic_frames", rises, 5);
            check("periodic_first_load", first, 100);
            check("periodic_spacing", spacing_bad, 0);
            en_b = 1'b0;
            rises = 0;
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                if (busy_b && !prev_busy) rises++;
                if (done_b) dones_off++;
                prev_busy = busy_b;
            end
            check("disabled_no_frames", rises, 0);
            check("disabled_inflight_completes", dones_off, 1);
            check("disabled_idle", busy_b, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
